// File: rtl/peak_note_pkg.sv
// Shared types, note table and arithmetic helpers for the peak note finder.
package peak_note_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ISSUE_R,
        ST_WAIT_R,
        ST_CAPTURE_R,
        ST_ISSUE_I,
        ST_WAIT_I,
        ST_CAPTURE_I,
        ST_COMPARE,
        ST_MATCH,
        ST_DONE
    } state_t;

    localparam int MAX_NOTES = 8;
    localparam int NOTE_BINS [0:MAX_NOTES-1] = '{165, 110, 147, 196, 247, 330, 0, 0};

    function automatic logic [31:0] abs_sat(input logic signed [31:0] v);
        if (v == 32'sh8000_0000)
            return 32'h7FFF_FFFF;
        return (v < 0) ? -v : v;
    endfunction

    // Clamp a value into the signed range of a w-bit word.
    function automatic logic signed [31:0] sat_resize(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/peak_note_finder_matcher.sv
// Walks the note table one entry per cycle and keeps the entry nearest to peak_bin.
module note_matcher #(
    parameter int ADDR_W  = 11,
    parameter int N_NOTES = 6,
    parameter int DIFF_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] peak_bin,
    output logic              valid,
    output logic [2:0]        note,
    output logic [DIFF_W-1:0] difference
);
    import peak_note_pkg::*;

    logic [2:0]               k_reg;
    logic [2:0]               best_k_reg;
    logic signed [ADDR_W+1:0] best_d_reg;
    logic [ADDR_W+1:0]        best_abs_reg;
    logic                     valid_reg;
    logic signed [ADDR_W+1:0] d;
    logic [ADDR_W+1:0]        abs_d;

    assign d     = $signed({2'b00, peak_bin}) - $signed((ADDR_W+2)'(NOTE_BINS[k_reg]));
    assign abs_d = d[ADDR_W+1] ? $unsigned(-d) : $unsigned(d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg        <= '0;
            best_k_reg   <= '0;
            best_d_reg   <= '0;
            best_abs_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (en && !valid_reg) begin
            // Entry 0 always seeds the search; later entries need a strictly smaller distance.
            if (k_reg == 3'd0 || abs_d < best_abs_reg) begin
                best_k_reg   <= k_reg;
                best_d_reg   <= d;
                best_abs_reg <= abs_d;
            end
            if (int'(k_reg) == N_NOTES - 1) begin
                k_reg     <= '0;
                valid_reg <= 1'b1;
            end else begin
                k_reg <= k_reg + 3'd1;
            end
        end else begin
            k_reg     <= '0;
            valid_reg <= 1'b0;
        end
    end

    assign valid      = valid_reg;
    assign note       = best_k_reg;
    assign difference = DIFF_W'(sat_resize(32'(best_d_reg), DIFF_W));

endmodule

// File: rtl/peak_note_finder.sv
// Scans a re/im spectrum RAM for the strongest bin and maps it onto the nearest tuning note.
module peak_note_finder #(
    parameter int DATA_W      = 10,
    parameter int ADDR_W      = 11,
    parameter int BIN_FIRST   = 1,
    parameter int BIN_LAST    = 511,
    parameter int IMAG_OFFSET = 1024,
    parameter int MEM_LAT     = 2,
    parameter int N_NOTES     = 6,
    parameter int DIFF_W      = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_data,
    input  logic [DATA_W:0]          threshold,
    output logic [ADDR_W-1:0]        peak_bin,
    output logic [DATA_W:0]          peak_mag,
    output logic [2:0]               note,
    output logic [DIFF_W-1:0]        difference,
    output logic                     no_signal
);
    import peak_note_pkg::*;

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(BIN_FIRST);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(BIN_LAST);
    localparam logic [ADDR_W-1:0] IMAG_A  = ADDR_W'(IMAG_OFFSET);

    state_t                    state_reg, state_next;
    logic [ADDR_W-1:0]         index_reg;
    logic [WAIT_W-1:0]         wait_cnt_reg;
    logic signed [DATA_W-1:0]  re_reg, im_reg;
    logic [DATA_W:0]           thr_reg;
    logic [DATA_W:0]           best_mag_reg;
    logic [ADDR_W-1:0]         best_bin_reg;
    logic [ADDR_W-1:0]         mem_addr_reg;
    logic                      done_reg, no_signal_reg;
    logic [ADDR_W-1:0]         peak_bin_reg;
    logic [DATA_W:0]           peak_mag_reg;
    logic [2:0]                note_reg;
    logic [DIFF_W-1:0]         diff_reg;
    logic [DATA_W:0]           mag;
    logic                      wait_done, match_valid;
    logic [2:0]                match_note;
    logic [DIFF_W-1:0]         match_diff;

    // DATA_W+1 bits hold |re|+|im| exactly, including two most-negative samples.
    assign mag       = (DATA_W+1)'(abs_sat(32'(re_reg))) + (DATA_W+1)'(abs_sat(32'(im_reg)));
    assign wait_done = (int'(wait_cnt_reg) == MEM_LAT - 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (start) state_next = ST_ISSUE_R;
            ST_ISSUE_R:   state_next = (MEM_LAT == 1) ? ST_CAPTURE_R : ST_WAIT_R;
            ST_WAIT_R:    if (wait_done) state_next = ST_CAPTURE_R;
            ST_CAPTURE_R: state_next = ST_ISSUE_I;
            ST_ISSUE_I:   state_next = (MEM_LAT == 1) ? ST_CAPTURE_I : ST_WAIT_I;
            ST_WAIT_I:    if (wait_done) state_next = ST_CAPTURE_I;
            ST_CAPTURE_I: state_next = ST_COMPARE;
            ST_COMPARE:   state_next = (index_reg == LAST_A) ? ST_MATCH : ST_ISSUE_R;
            ST_MATCH:     if (match_valid) state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_reg     <= '0;
            wait_cnt_reg  <= '0;
            re_reg        <= '0;
            im_reg        <= '0;
            thr_reg       <= '0;
            best_mag_reg  <= '0;
            best_bin_reg  <= '0;
            mem_addr_reg  <= '0;
            done_reg      <= 1'b0;
            no_signal_reg <= 1'b0;
            peak_bin_reg  <= '0;
            peak_mag_reg  <= '0;
            note_reg      <= '0;
            diff_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: if (start) begin
                    thr_reg      <= threshold;
                    index_reg    <= FIRST_A;
                    best_mag_reg <= '0;
                    best_bin_reg <= FIRST_A;
                end
                ST_ISSUE_R: begin
                    mem_addr_reg <= index_reg;
                    wait_cnt_reg <= '0;
                end
                ST_ISSUE_I: begin
                    mem_addr_reg <= index_reg + IMAG_A;
                    wait_cnt_reg <= '0;
                end
                ST_WAIT_R, ST_WAIT_I: wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                ST_CAPTURE_R: re_reg <= mem_data;
                ST_CAPTURE_I: im_reg <= mem_data;
                ST_COMPARE: begin
                    if (mag > best_mag_reg) begin
                        best_mag_reg <= mag;
                        best_bin_reg <= index_reg;
                    end
                    index_reg <= index_reg + ADDR_W'(1);
                end
                ST_DONE: begin
                    done_reg     <= 1'b1;
                    peak_bin_reg <= best_bin_reg;
                    peak_mag_reg <= best_mag_reg;
                    if (best_mag_reg < thr_reg) begin
                        no_signal_reg <= 1'b1;
                        note_reg      <= '0;
                        diff_reg      <= '0;
                    end else begin
                        no_signal_reg <= 1'b0;
                        note_reg      <= match_note;
                        diff_reg      <= match_diff;
                    end
                end
                default: ;
            endcase
        end
    end

    note_matcher #(
        .ADDR_W  (ADDR_W),
        .N_NOTES (N_NOTES),
        .DIFF_W  (DIFF_W)
    ) u_matcher (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_reg == ST_MATCH),
        .peak_bin   (best_bin_reg),
        .valid      (match_valid),
        .note       (match_note),
        .difference (match_diff)
    );

    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign mem_addr   = mem_addr_reg;
    assign peak_bin   = peak_bin_reg;
    assign peak_mag   = peak_mag_reg;
    assign note       = note_reg;
    assign difference = diff_reg;
    assign no_signal  = no_signal_reg;

endmodule

// File: tb/tb_peak_note_finder.sv
// Directed bench: three finders (MEM_LAT 2, 1, 4; the last with a 4-bit difference) share one spectrum.
module tb_peak_note_finder;
    localparam int DW = 10;
    localparam int AW = 11;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW:0]   threshold = '0;

    logic signed [DW-1:0] spec_mem [0:2047];

    logic              busy_v   [NI];
    logic              done_v   [NI];
    logic              nosig_v  [NI];
    logic [AW-1:0]     addr_v   [NI];
    logic [AW-1:0]     bin_v    [NI];
    logic [DW:0]       mag_v    [NI];
    logic [2:0]        note_v   [NI];
    logic signed [9:0] diff_v   [NI];
    int                lat_v    [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        localparam int DFW = (gi == 2) ? 4 : 10;
        logic [AW-1:0]        pipe [0:3];
        logic signed [DW-1:0] rd;
        logic [DFW-1:0]       dw;

        always @(posedge clk) begin
            pipe[0] <= addr_v[gi];
            for (int i = 1; i < 4; i++)
                pipe[i] <= pipe[i-1];
        end

        if (LAT == 1) begin : g_comb
            assign rd = spec_mem[addr_v[gi]];
        end else begin : g_pipe
            assign rd = spec_mem[pipe[LAT-2]];
        end

        assign diff_v[gi] = 10'(signed'(dw));

        peak_note_finder #(
            .MEM_LAT (LAT),
            .DIFF_W  (DFW)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .busy       (busy_v[gi]),
            .done       (done_v[gi]),
            .mem_addr   (addr_v[gi]),
            .mem_data   (rd),
            .threshold  (threshold),
            .peak_bin   (bin_v[gi]),
            .peak_mag   (mag_v[gi]),
            .note       (note_v[gi]),
            .difference (dw),
            .no_signal  (nosig_v[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        else
            n_pass++;
    endtask

    function automatic int exp_lat(input int i);
        case (i)
            0:       return 511 * 7 + 8;
            1:       return 511 * 5 + 8;
            default: return 511 * 11 + 8;
        endcase
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 2048; a++)
            spec_mem[a] = '0;
    endtask

    // Start all finders together; optionally poke start again mid-scan at cycle poke.
    task automatic run_scan(input string tag, input logic [DW:0] thr, input int poke);
        bit all_done;
        @(negedge clk);
        threshold = thr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        threshold = ~thr;
        for (int i = 0; i < NI; i++)
            lat_v[i] = -1;
        all_done = 1'b0;
        for (int cyc = 1; cyc <= 7000 && !all_done; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1)
                check({tag, ".busy"}, 32'(busy_v[0]), 1);
            start = (poke != 0 && cyc == poke);
            for (int i = 0; i < NI; i++)
                if (lat_v[i] < 0 && done_v[i] === 1'b1) begin
                    lat_v[i] = cyc;
                    if (i == 0)
                        check({tag, ".busy_end"}, 32'(busy_v[0]), 0);
                end
            all_done = (lat_v[0] >= 0) && (lat_v[1] >= 0) && (lat_v[2] >= 0);
        end
        start = 1'b0;
        for (int i = 0; i < NI; i++)
            check($sformatf("%s.lat%0d", tag, i), lat_v[i], exp_lat(i));
    endtask

    task automatic check_res(input string tag, input int bin, input int mag, input int nt,
                             input int d10, input int d4, input int ns);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s.bin%0d", tag, i), 32'(bin_v[i]), bin);
            check($sformatf("%s.mag%0d", tag, i), 32'(mag_v[i]), mag);
            check($sformatf("%s.note%0d", tag, i), 32'(note_v[i]), nt);
            check($sformatf("%s.diff%0d", tag, i), 32'(diff_v[i]), (i == 2) ? d4 : d10);
            check($sformatf("%s.nosig%0d", tag, i), 32'(nosig_v[i]), ns);
        end
        $display("scan %s: bin=%0d mag=%0d note=%0d diff=%0d nosig=%0d lat=%0d",
                 tag, bin_v[0], mag_v[0], note_v[0], diff_v[0], nosig_v[0], lat_v[0]);
    endtask

    task automatic drain();
        int guard = 0;
        while ((busy_v[0] | busy_v[1] | busy_v[2]) && guard < 12000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_idle", 32'(busy_v[0] | busy_v[1] | busy_v[2]), 0);
    endtask

    initial begin
        int first, second, guard;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy_v[0]), 0);
        check("rst.done", 32'(done_v[0]), 0);
        check("rst.addr", 32'(addr_v[0]), 0);
        check("rst.bin",  32'(bin_v[0]), 0);
        check("rst.nosig", 32'(nosig_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        spec_mem[200] = 10'sd300;
        spec_mem[1224] = -10'sd100;
        run_scan("single", 11'd0, 0);
        check_res("single", 200, 400, 3, 4, 4, 0);

        clear_mem();
        spec_mem[120] = 10'sd50;
        spec_mem[300] = -10'sd20;
        spec_mem[1324] = 10'sd30;
        run_scan("tie", 11'd0, 0);
        check_res("tie", 120, 50, 1, 10, 7, 0);

        clear_mem();
        spec_mem[330] = -10'sd512;
        spec_mem[1354] = -10'sd512;
        run_scan("mostneg", 11'd0, 0);
        check_res("mostneg", 330, 1024, 5, 0, 0, 0);

        clear_mem();
        spec_mem[150] = 10'sd25;
        spec_mem[1174] = -10'sd15;
        run_scan("thr41", 11'd41, 0);
        check_res("thr41", 150, 40, 0, 0, 0, 1);
        run_scan("thr40", 11'd40, 0);
        check_res("thr40", 150, 40, 2, 3, 3, 0);

        clear_mem();
        run_scan("zero", 11'd0, 0);
        check_res("zero", 1, 0, 1, -109, -8, 0);

        spec_mem[200] = 10'sd300;
        spec_mem[1224] = -10'sd100;
        run_scan("poke", 11'd0, 1000);
        check_res("poke", 200, 400, 3, 4, 4, 0);

        // Start held high: the second scan is sampled in the IDLE cycle after done.
        @(negedge clk);
        threshold = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        first = -1;
        second = -1;
        for (int cyc = 1; cyc <= 8000 && second < 0; cyc++) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        start = 1'b0;
        check("held.first", first, 3585);
        check("held.second", second, 2 * 3585 + 1);
        $display("held start: first done %0d second done %0d", first, second);
        drain();

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (addr_v[0] != 11'd300 && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("rstmid.reach", 32'(addr_v[0]), 300);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid.busy",  32'(busy_v[0]), 0);
        check("rstmid.done",  32'(done_v[0]), 0);
        check("rstmid.addr",  32'(addr_v[0]), 0);
        check("rstmid.bin",   32'(bin_v[0]), 0);
        check("rstmid.mag",   32'(mag_v[0]), 0);
        check("rstmid.note",  32'(note_v[0]), 0);
        check("rstmid.diff",  32'(diff_v[0]), 0);
        check("rstmid.nosig", 32'(nosig_v[0]), 0);
        check("rstmid.busy2", 32'(busy_v[2]), 0);
        $display("reset mid-scan: busy=%0d addr=%0d bin=%0d", busy_v[0], addr_v[0], bin_v[0]);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan("after_rst", 11'd0, 0);
        check_res("after_rst", 200, 400, 3, 4, 4, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
